mux_scan_sequencer: RTL and testbench
=====================================

MUX_SCAN_SEQUENCER -- requirements
Module: mux_scan_sequencer

Interface
REQ-001 Parameter DWELL_W, default 8, sets the width of the dwell counter and the dwell input.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  single-cycle request to begin a sweep.
REQ-005 stop  input  1  abort of the current sweep.
REQ-006 cont  input  1  continuous mode; when high, a new sweep begins automatically after each completed sweep.
REQ-007 en_mask  input  4  channels to scan; bit n enables mux input n.
REQ-008 dwell  input  DWELL_W  extra settle cycles per channel before capture.
REQ-009 mux_out  input  1  selected bit returned from the downstream 4-to-1 mux.
REQ-010 sel  output  2  channel select driven into the 4-to-1 mux sel port.
REQ-011 busy  output  1  high while a sweep is in progress.
REQ-012 sample  output  4  last completed sweep result; bit n holds the value captured from channel n.
REQ-013 sample_valid  output  1  one-cycle pulse when sample updates.
REQ-014 err  output  1  one-cycle pulse when start is seen with en_mask == 0.

Function
REQ-015 The FSM SHALL have states IDLE, DWELL and DONE.
REQ-016 In IDLE, start=1 with en_mask!=0 SHALL latch en_mask, dwell and cont, load sel with the lowest enabled channel, clear the counter and enter DWELL.
REQ-017 In IDLE, start=1 with en_mask==0 SHALL pulse err for one cycle and remain in IDLE.
REQ-018 In DWELL, the counter SHALL increment each cycle; when counter == latched dwell, mux_out SHALL be captured into shadow bit [sel].
REQ-019 On capture, if a higher enabled channel exists, sel SHALL advance to it and the counter SHALL clear; otherwise the FSM SHALL enter DONE. Disabled channels are skipped and consume no cycles.
REQ-020 Each enabled channel SHALL occupy exactly dwell+1 cycles; dwell=0 captures on the first DWELL cycle.
REQ-021 On entry to DONE, sample SHALL load the shadow, with disabled-channel bits forced to 0, and sample_valid SHALL be high for exactly that DONE cycle.
REQ-022 Latency: with N enabled channels, start sampled in cycle 0 SHALL give sample_valid in cycle N*(dwell+1)+1.
REQ-023 From DONE, the FSM SHALL go to DWELL at the lowest latched channel if latched cont=1; otherwise it SHALL go to IDLE. Continuous mode re-uses the latched mask and dwell.
REQ-024 stop=1 in DWELL or DONE SHALL move the FSM to IDLE on the next edge, with no sample_valid for a sweep not yet completed and sample unchanged.
REQ-025 stop has priority over a same-cycle capture or DONE transition; a DONE cycle already in progress keeps its sample_valid.
REQ-026 start while busy SHALL be ignored; en_mask and dwell changes while busy SHALL have no effect until the next start.
REQ-027 start and stop both high in IDLE SHALL be treated as stop (remain IDLE, no err).
REQ-028 busy SHALL be high in DWELL and DONE and low in IDLE.
REQ-029 The counter SHALL never wrap: the dwell comparison terminates it at dwell, maximum 2^DWELL_W-1.
REQ-030 In IDLE, sel SHALL hold 0.

Reset
REQ-031 rst=1 SHALL force IDLE, sel=0, busy=0, sample=0, sample_valid=0, err=0, counter=0, shadow=0, and clear the latched mask, dwell and cont.
REQ-032 rst mid-sweep SHALL abort immediately, with no sample_valid; rst overrides start and stop.

Structure
REQ-033 Package mux_scan_pkg SHALL hold the state enum (IDLE, DWELL, DONE) and the constants NUM_CH=4 and SEL_W=2.
REQ-034 Sub-module mux_scan_next_ch SHALL be combinational: (mask, current sel) -> next higher enabled channel and a found flag; the same block with sel forced low gives the lowest enabled channel.

Verification
REQ-035 Full sweep: en_mask=4'b1111, dwell=2, mux inputs i=4'b1010, pulse start -> sel steps 0,1,2,3 every 3 cycles; sample_valid in cycle 13; sample=4'b1010.
REQ-036 Sparse mask: en_mask=4'b1001, dwell=0, i=4'b1111 -> sel goes 0 then 3; sample_valid in cycle 3; sample=4'b1001.
REQ-037 Empty mask: en_mask=0, start -> err high for 1 cycle; busy stays 0; no sample_valid.
REQ-038 Abort: en_mask=4'b1111, dwell=5, stop in cycle 8 -> IDLE in cycle 9; sel=0; sample keeps its previous value; no sample_valid.
REQ-039 Continuous: cont=1, en_mask=4'b0110, dwell=1 -> sample_valid every 5 cycles; changing en_mask mid-run has no effect.
REQ-040 Reset mid-sweep: rst asserted in cycle 4 of a sweep -> all outputs 0 on the next cycle; a start afterwards begins a clean sweep.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared state encoding and channel constants for the mux scan sequencer
package mux_scan_pkg;
    localparam int NUM_CH = 4;
    localparam int SEL_W = 2;
    typedef enum logic [1:0] {IDLE, DWELL, DONE} state_t;
endpackage

// File: rtl/mux_scan_next_ch.sv
// mux_scan_next_ch: finds the next enabled channel above sel (or at/above it when incl is set)
module mux_scan_next_ch
    import mux_scan_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [SEL_W-1:0]  sel,
    input  logic              incl,
    output logic [SEL_W-1:0]  next_ch,
    output logic              found
);
    always_comb begin
        found = 1'b0;
        next_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (mask[i] && (i > int'(sel) || (incl && i == int'(sel)))) begin
                found = 1'b1;
                next_ch = SEL_W'(i);
            end
    end
endmodule

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: sweeps enabled channels of a 4-to-1 mux, dwelling per channel before capture
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               cont,
    input  logic [NUM_CH-1:0]  en_mask,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               mux_out,
    output logic [SEL_W-1:0]   sel,
    output logic               busy,
    output logic [NUM_CH-1:0]  sample,
    output logic               sample_valid,
    output logic               err
);
    state_t state, state_n;
    logic [SEL_W-1:0] sel_n, next_ch, low_ch;
    logic [DWELL_W-1:0] cnt, cnt_n, dwell_q, dwell_n;
    logic [NUM_CH-1:0] mask_q, mask_n, shadow, shadow_n, shadow_cap, sample_n;
    logic cont_q, cont_n, err_n, next_found, low_found;

    mux_scan_next_ch u_next (
        .mask(mask_q), .sel(sel), .incl(1'b0), .next_ch(next_ch), .found(next_found)
    );
    // In IDLE the lowest channel comes from the live mask, afterwards from the latched one
    mux_scan_next_ch u_low (
        .mask(state == IDLE ? en_mask : mask_q), .sel('0), .incl(1'b1),
        .next_ch(low_ch), .found(low_found)
    );

    assign busy = state != IDLE;
    assign sample_valid = state == DONE;

    always_comb begin
        state_n = state;
        sel_n = sel;
        cnt_n = cnt;
        mask_n = mask_q;
        dwell_n = dwell_q;
        cont_n = cont_q;
        shadow_n = shadow;
        sample_n = sample;
        err_n = 1'b0;
        shadow_cap = shadow;
        shadow_cap[sel] = mux_out;
        case (state)
            IDLE: if (start && !stop) begin
                err_n = !low_found;
                if (low_found) begin
                    state_n = DWELL;
                    mask_n = en_mask;
                    dwell_n = dwell;
                    cont_n = cont;
                    sel_n = low_ch;
                    cnt_n = '0;
                    shadow_n = '0;
                end
            end
            DWELL: if (stop) begin
                state_n = IDLE;
                sel_n = '0;
                cnt_n = '0;
            end else if (cnt == dwell_q) begin
                shadow_n = shadow_cap;
                cnt_n = '0;
                sel_n = next_found ? next_ch : sel;
                state_n = next_found ? DWELL : DONE;
                sample_n = next_found ? sample : shadow_cap & mask_q;
            end else begin
                cnt_n = cnt + 1'b1;
            end
            DONE: begin
                state_n = (stop || !cont_q) ? IDLE : DWELL;
                sel_n = (stop || !cont_q) ? '0 : low_ch;
                cnt_n = '0;
                shadow_n = '0;
            end
            default: begin
                state_n = IDLE;
                sel_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sel <= '0;
            cnt <= '0;
            mask_q <= '0;
            dwell_q <= '0;
            cont_q <= 1'b0;
            shadow <= '0;
            sample <= '0;
            err <= 1'b0;
        end else begin
            state <= state_n;
            sel <= sel_n;
            cnt <= cnt_n;
            mask_q <= mask_n;
            dwell_q <= dwell_n;
            cont_q <= cont_n;
            shadow <= shadow_n;
            sample <= sample_n;
            err <= err_n;
        end
    end
endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb_mux_scan_sequencer: scoreboard bench; expected sweep results are queued at start and popped on sample_valid
module tb_mux_scan_sequencer;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0, cont = 1'b0;
    logic [3:0] en_mask = '0, mux_in = '0;
    logic [7:0] dwell = '0;
    logic mux_out, busy, sample_valid, err;
    logic [1:0] sel;
    logic [3:0] sample;

    typedef struct {
        logic [3:0] s;
        int c;
    } exp_t;
    exp_t q[$];
    exp_t e;
    int cyc = 0, tests = 0, fails = 0;

    mux_scan_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .cont(cont),
        .en_mask(en_mask), .dwell(dwell), .mux_out(mux_out), .sel(sel),
        .busy(busy), .sample(sample), .sample_valid(sample_valid), .err(err)
    );

    assign mux_out = mux_in[sel];
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk)
        if (sample_valid) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_valid: got sample %b expected no valid at cycle %0d", sample, cyc);
            end else begin
                e = q.pop_front();
                chk("sample", sample, e.s);
                chk("valid_cycle", cyc, e.c);
            end
        end

    task automatic goto(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // A sweep over N channels with dwell d started in cycle c completes in cycle c+N*(d+1)+1
    task automatic pulse_start(input logic [3:0] m, input logic [7:0] d, input logic [3:0] iv,
                               input bit c_in, input bit push, output int c);
        en_mask = m;
        dwell = d;
        mux_in = iv;
        cont = c_in;
        start = 1'b1;
        c = cyc;
        if (push) q.push_back('{iv & m, cyc + $countones(m) * (int'(d) + 1) + 1});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while ((busy || q.size() != 0) && k < budget) begin
            @(negedge clk);
            k++;
        end
        tests++;
        if (busy || q.size() != 0) begin
            fails++;
            $display("FAIL wait_idle: got busy=%0b pending=%0d expected idle with none pending", busy, q.size());
            q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish by time 200000");
        $fatal(1);
    end

    initial begin
        int c;
        logic [3:0] m, iv;
        logic [7:0] d;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_sel", sel, 0);
        chk("rst_sample", sample, 0);
        chk("rst_valid", sample_valid, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        @(negedge clk);
        pulse_start(4'b1111, 8'd2, 4'b1010, 1'b0, 1'b1, c);
        for (int k = 0; k < 4; k++) begin
            goto(c + 1 + 3 * k);
            chk("full_sel", sel, k);
        end
        wait_idle(50);
        pulse_start(4'b1001, 8'd0, 4'b1111, 1'b0, 1'b1, c);
        goto(c + 1);
        chk("sparse_sel0", sel, 0);
        goto(c + 2);
        chk("sparse_sel3", sel, 3);
        wait_idle(50);
        pulse_start(4'b0000, 8'd3, 4'b1111, 1'b0, 1'b0, c);
        chk("empty_err", err, 1);
        chk("empty_busy", busy, 0);
        @(negedge clk);
        chk("empty_err_drop", err, 0);
        chk("empty_busy2", busy, 0);
        en_mask = 4'b1111;
        start = 1'b1;
        stop = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop = 1'b0;
        chk("startstop_err", err, 0);
        chk("startstop_busy", busy, 0);
        pulse_start(4'b1111, 8'd5, 4'b0110, 1'b0, 1'b0, c);
        goto(c + 8);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_sel", sel, 0);
        chk("abort_sample", sample, 4'b1001);
        pulse_start(4'b0110, 8'd1, 4'b1100, 1'b1, 1'b1, c);
        for (int k = 2; k <= 4; k++) q.push_back('{4'b0100, c + 5 * k});
        cont = 1'b0;
        goto(c + 7);
        en_mask = 4'b1111;
        dwell = 8'd0;
        goto(c + 20);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("cont_stop_busy", busy, 0);
        wait_idle(20);
        pulse_start(4'b1111, 8'd1, 4'b1111, 1'b0, 1'b0, c);
        goto(c + 4);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_sel", sel, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_sample", sample, 0);
        chk("midrst_valid", sample_valid, 0);
        chk("midrst_err", err, 0);
        rst = 1'b0;
        @(negedge clk);
        pulse_start(4'b0101, 8'd1, 4'b0111, 1'b0, 1'b1, c);
        wait_idle(50);
        for (int n = 0; n < 24; n++) begin
            m = 4'($urandom_range(15, 1));
            d = 8'($urandom_range(4, 0));
            iv = 4'($urandom);
            pulse_start(m, d, iv, 1'b0, 1'b1, c);
            if ($urandom_range(1, 0) == 1) begin
                goto(c + 2);
                en_mask = 4'($urandom);
                dwell = 8'($urandom);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                chk("busy_start_err", err, 0);
            end
            wait_idle(100);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
